hilo_muldiv_ctrl: RTL

//  Sequencer and owner of the HI/LO register pair for the EX stage.

---
 rtl/hilo_muldiv_ctrl.sv | 95 +++++++++
 1 files changed

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: HI/LO owner sequencing external multiply, restoring divide and MTHI/MTLO.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               flush,
  output logic               mul_sign,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_p,
  output logic               busy,
  output logic               done,
  output logic               div0,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam int MAXC = WIDTH > MUL_LAT ? WIDTH : MUL_LAT;
  localparam int CW = $clog2(MAXC) + 1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, rem_nx, quo_nx, a_abs, b_abs;
  logic [WIDTH:0] trial;
  logic qneg, rneg, div0_r, sgn, acc, last_mul, last_div;
  always_comb begin
    acc = !rst && state == IDLE && op_valid && !flush;
    sgn = op == 3'b010;
    last_mul = cnt == CW'(MUL_LAT - 1);
    last_div = cnt == CW'(WIDTH - 1);
    busy = (acc && !op[2]) || ((state == MUL || state == DIV) && !flush);
    done = state == DONE;
    div0 = done && div0_r;
    a_abs = sgn && src_a[WIDTH-1] ? -src_a : src_a;
    b_abs = sgn && src_b[WIDTH-1] ? -src_b : src_b;
    // restoring step: shift next dividend bit into the partial remainder, subtract if it fits
    trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    rem_nx = trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], !trial[WIDTH]};
    state_nx = flush ? IDLE :
               state == IDLE ? (acc && !op[2] ? (op[1] ? (src_b == '0 ? DONE : DIV) : MUL) : IDLE) :
               state == MUL  ? (last_mul ? DONE : MUL) :
               state == DIV  ? (last_div ? DONE : DIV) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
      mul_a <= '0;
      mul_b <= '0;
      mul_sign <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      div0_r <= 1'b0;
    end else begin
      cnt <= (state == MUL || state == DIV) ? cnt + CW'(1) : '0;
      div0_r <= acc && op[2:1] == 2'b01 && src_b == '0;
      if (acc && op == 3'b100) hi <= src_a;
      if (acc && op == 3'b101) lo <= src_a;
      if (acc && op[2:1] == 2'b00) begin
        mul_a <= src_a;
        mul_b <= src_b;
        mul_sign <= !op[0];
      end
      if (acc && op[2:1] == 2'b01) begin
        rem <= '0;
        quo <= a_abs;
        dvs <= b_abs;
        qneg <= sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        rneg <= sgn && src_a[WIDTH-1];
      end
      if (state == MUL && !flush && last_mul) {hi, lo} <= mul_p;
      if (state == DIV && !flush) begin
        rem <= rem_nx;
        quo <= quo_nx;
        if (last_div) begin
          lo <= qneg ? -quo_nx : quo_nx;
          hi <= rneg ? -rem_nx : rem_nx;
        end
      end
    end
  end
endmodule
